// File: rtl/uart_tx_sched.sv
// Byte FIFO plus start-pulse sequencer feeding the UART_TX serializer.
// Each start_TX is held off until the previous byte's tx_active handshake completes.
module uart_tx_sched #(
  parameter int DEPTH_LOG2  = 4,
  parameter int ACT_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  sync_reset,
  input  logic                  push,
  input  logic [7:0]            push_data,
  input  logic                  flush,
  input  logic                  clr_err,
  input  logic                  tx_active,
  output logic                  start_TX,
  output logic [7:0]            SBUF_in,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  full,
  output logic                  empty,
  output logic                  busy,
  output logic                  ovf_err,
  output logic                  to_err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);
  localparam logic [DEPTH_LOG2:0]   LVL_ONE   = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2:0]   DEPTH_LVL = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [7:0]            TIMEOUT_LOAD = 8'(ACT_TIMEOUT);

  typedef enum logic [1:0] {IDLE, START, WAIT_ACT, WAIT_DONE} state_t;

  state_t                 state_reg;
  logic [7:0]             mem [DEPTH];
  logic [DEPTH_LOG2-1:0]  wr_ptr_reg;
  logic [DEPTH_LOG2-1:0]  rd_ptr_reg;
  logic [DEPTH_LOG2:0]    level_reg;
  logic [7:0]             timer_reg;
  logic [7:0]             sbuf_reg;
  logic                   start_reg;
  logic                   ovf_reg;
  logic                   to_reg;

  logic pop;
  logic push_ok;
  logic ovf_set;
  logic to_set;

  assign empty = (level_reg == '0);
  assign full  = (level_reg == DEPTH_LVL);

  // A pop at full frees a slot in the same cycle, so a simultaneous push is accepted.
  assign pop     = (state_reg == IDLE) && !empty && !flush;
  assign push_ok = push && !flush && (!full || pop);
  assign ovf_set = push && !flush && full && !pop;
  assign to_set  = (state_reg == WAIT_ACT) && !tx_active && (timer_reg == '0);

  assign level    = level_reg;
  assign start_TX = start_reg;
  assign SBUF_in  = sbuf_reg;
  assign ovf_err  = ovf_reg;
  assign to_err   = to_reg;
  assign busy     = (state_reg != IDLE) || !empty;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
      ovf_reg    <= 1'b0;
    end else if (sync_reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
      ovf_reg    <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
        level_reg  <= '0;
      end else begin
        if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
        if (pop)     rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
        case ({push_ok, pop})
          2'b10:   level_reg <= level_reg + LVL_ONE;
          2'b01:   level_reg <= level_reg - LVL_ONE;
          default: level_reg <= level_reg;
        endcase
      end
      ovf_reg <= ovf_set | (ovf_reg & ~clr_err);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      timer_reg <= '0;
      sbuf_reg  <= '0;
      start_reg <= 1'b0;
      to_reg    <= 1'b0;
    end else if (sync_reset) begin
      state_reg <= IDLE;
      timer_reg <= '0;
      sbuf_reg  <= '0;
      start_reg <= 1'b0;
      to_reg    <= 1'b0;
    end else begin
      start_reg <= 1'b0;
      to_reg    <= to_set | (to_reg & ~clr_err);
      case (state_reg)
        IDLE: begin
          if (pop) begin
            sbuf_reg  <= mem[rd_ptr_reg];
            start_reg <= 1'b1;
            state_reg <= START;
          end
        end
        START: begin
          timer_reg <= TIMEOUT_LOAD;
          state_reg <= WAIT_ACT;
        end
        WAIT_ACT: begin
          if (tx_active)              state_reg <= WAIT_DONE;
          else if (timer_reg == '0)   state_reg <= IDLE;
          else                        timer_reg <= timer_reg - 8'd1;
        end
        WAIT_DONE: begin
          if (!tx_active) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Randomized and directed bench for uart_tx_sched with a queue-based reference model
// and a behavioural serializer that holds tx_active for a chosen frame length.
module tb_uart_tx_sched;

  localparam int DL    = 4;
  localparam int DEPTH = 1 << DL;
  localparam int TMO   = 3;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        sync_reset;
  logic        push;
  logic [7:0]  push_data;
  logic        flush;
  logic        clr_err;
  logic        tx_active;
  logic        start_TX;
  logic [7:0]  SBUF_in;
  logic [DL:0] level;
  logic        full;
  logic        empty;
  logic        busy;
  logic        ovf_err;
  logic        to_err;

  always #5 clk = ~clk;

  uart_tx_sched #(.DEPTH_LOG2(DL), .ACT_TIMEOUT(TMO)) dut (
    .clk(clk), .reset_n(reset_n), .sync_reset(sync_reset),
    .push(push), .push_data(push_data), .flush(flush), .clr_err(clr_err),
    .tx_active(tx_active), .start_TX(start_TX), .SBUF_in(SBUF_in),
    .level(level), .full(full), .empty(empty), .busy(busy),
    .ovf_err(ovf_err), .to_err(to_err)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: queue contents, earliest next pop edge, sticky flags.
  logic [7:0] mq[$];
  int         cyc;
  int         next_pop;
  int         to_at;
  bit         m_ovf, m_to, m_start;
  logic [7:0] m_sbuf;
  // Serializer environment: frame_len 0 means tx_active never rises.
  int         frame_len;
  int         pend_len;
  int         ser_cnt;
  int         starts;
  int         peak_level;

  task automatic check_value(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
  endtask

  task automatic model_reset();
    mq.delete();
    next_pop = 0;
    to_at    = -1;
    m_ovf    = 0;
    m_to     = 0;
    m_start  = 0;
    m_sbuf   = 8'h00;
    pend_len = 0;
    ser_cnt  = 0;
    tx_active = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_value({tag, "_level"}, level, 0);
    check_value({tag, "_empty"}, empty, 1);
    check_value({tag, "_full"}, full, 0);
    check_value({tag, "_busy"}, busy, 0);
    check_value({tag, "_start"}, start_TX, 0);
    check_value({tag, "_sbuf"}, SBUF_in, 0);
    check_value({tag, "_ovf"}, ovf_err, 0);
    check_value({tag, "_to"}, to_err, 0);
  endtask

  task automatic cycle(input bit p, input logic [7:0] d, input bit f, input bit c, input bit sr);
    bit st_pre, pop, ovf_ev, to_ev;
    push = p; push_data = d; flush = f; clr_err = c; sync_reset = sr;
    st_pre = start_TX;
    @(posedge clk); #1;
    cyc++;
    if (sr) begin
      model_reset();
    end else begin
      pop = (mq.size() > 0) && !f && (cyc >= next_pop);
      if (pop) begin
        m_sbuf   = mq.pop_front();
        pend_len = frame_len;
        next_pop = cyc + ((frame_len == 0) ? TMO + 3 : frame_len + 3);
        to_at    = (frame_len == 0) ? cyc + TMO + 2 : -1;
      end
      to_ev  = (cyc == to_at);
      ovf_ev = 0;
      if (f) mq.delete();
      else if (p) begin
        if (mq.size() < DEPTH) mq.push_back(d);
        else ovf_ev = 1;
      end
      m_start = pop;
      if (c) begin m_ovf = 0; m_to = 0; end
      if (ovf_ev) m_ovf = 1;
      if (to_ev)  m_to  = 1;
      if (st_pre && pend_len > 0) begin
        tx_active = 1'b1;
        ser_cnt   = pend_len;
      end else if (ser_cnt > 0) begin
        ser_cnt--;
        if (ser_cnt == 0) tx_active = 1'b0;
      end
    end
    check_value("level", level, mq.size());
    check_value("full", full, mq.size() == DEPTH);
    check_value("empty", empty, mq.size() == 0);
    check_value("busy", busy, (mq.size() > 0) || (cyc < next_pop - 1));
    check_value("start_TX", start_TX, m_start);
    check_value("SBUF_in", SBUF_in, m_sbuf);
    check_value("ovf_err", ovf_err, m_ovf);
    check_value("to_err", to_err, m_to);
    if (int'(level) > peak_level) peak_level = level;
    if (start_TX) begin
      starts++;
      $display("tx  cycle %0d  byte 0x%02h", cyc, SBUF_in);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 8'h00, 0, 0, 0);
  endtask

  task automatic async_reset_pulse();
    #2 reset_n = 1'b0;
    #1 check_reset_outputs("async_rst");
    #1 reset_n = 1'b1;
    model_reset();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int s0;
    reset_n = 1'b0; sync_reset = 1'b0; push = 1'b0; push_data = 8'h00;
    flush = 1'b0; clr_err = 1'b0;
    cyc = 0; starts = 0; peak_level = 0; frame_len = 5;
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_reset_outputs("por");
    reset_n = 1'b1;
    idle(2);

    // single byte with a long frame
    frame_len = 100;
    s0 = starts;
    cycle(1, 8'h55, 0, 0, 0);
    idle(1);
    check_value("single_start", start_TX, 1);
    check_value("single_sbuf", SBUF_in, 8'h55);
    idle(110);
    check_value("single_pulses", starts - s0, 1);

    // burst of 16 bytes, frame long enough that only the first pops early
    frame_len = 20;
    s0 = starts;
    peak_level = 0;
    for (int i = 1; i <= 16; i++) cycle(1, 8'(i), 0, 0, 0);
    idle(16 * 23 + 20);
    check_value("burst_peak", peak_level, 15);
    check_value("burst_pulses", starts - s0, 16);
    check_value("burst_ovf", ovf_err, 0);

    // overflow while the serializer is stalled in its frame
    frame_len = 40;
    cycle(1, 8'hA0, 0, 0, 0);
    idle(3);
    for (int i = 0; i < 16; i++) cycle(1, 8'hB0 + 8'(i), 0, 0, 0);
    check_value("ovf_full", full, 1);
    check_value("ovf_before", ovf_err, 0);
    cycle(1, 8'hCC, 0, 0, 0);
    check_value("ovf_set", ovf_err, 1);
    check_value("ovf_level", level, 16);
    cycle(0, 8'h00, 0, 1, 0);
    check_value("ovf_clr", ovf_err, 0);
    for (int k = 0; k < 200 && (cyc + 1 < next_pop); k++) idle(1);
    cycle(1, 8'hEE, 0, 0, 0);
    check_value("pushpop_ovf", ovf_err, 0);
    check_value("pushpop_level", level, 16);
    frame_len = 3;
    idle(16 * 6 + 80);

    // timeout with a dead serializer, then a normal byte
    frame_len = 0;
    cycle(1, 8'h11, 0, 0, 0);
    cycle(1, 8'h22, 0, 0, 0);
    for (int k = 0; k < 20 && !to_err; k++) idle(1);
    check_value("to_set", to_err, 1);
    frame_len = 5;
    idle(15);
    cycle(0, 8'h00, 0, 1, 0);

    // flush while a byte is in flight
    frame_len = 20;
    for (int i = 0; i < 5; i++) cycle(1, 8'h60 + 8'(i), 0, 0, 0);
    idle(2);
    cycle(0, 8'h00, 1, 0, 0);
    check_value("flush_level", level, 0);
    s0 = starts;
    idle(40);
    check_value("flush_no_start", starts - s0, 0);

    // synchronous reset in WAIT_ACT
    frame_len = 0;
    cycle(1, 8'h33, 0, 0, 0);
    idle(2);
    cycle(0, 8'h00, 0, 0, 1);
    check_reset_outputs("sync_rst");
    frame_len = 5;
    cycle(1, 8'h55, 0, 0, 0);
    idle(1);
    check_value("sync_rst_start", start_TX, 1);
    check_value("sync_rst_sbuf", SBUF_in, 8'h55);
    idle(12);

    // asynchronous reset in WAIT_ACT
    frame_len = 0;
    cycle(1, 8'h44, 0, 0, 0);
    idle(2);
    async_reset_pulse();
    frame_len = 5;
    cycle(1, 8'h55, 0, 0, 0);
    idle(1);
    check_value("async_rst_start", start_TX, 1);
    check_value("async_rst_sbuf", SBUF_in, 8'h55);
    idle(12);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      frame_len = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 12));
      cycle($urandom_range(0, 3) == 0, 8'($urandom), $urandom_range(0, 59) == 0,
            $urandom_range(0, 19) == 0, $urandom_range(0, 399) == 0);
    end
    frame_len = 4;
    idle(200);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
